// File: rtl/fsm_table_engine.sv
// fsm_table_engine: run-time programmable table-driven Mealy FSM; define FSM_OUT_REG_EN for a registered output
module fsm_table_engine #(
  parameter int NS = 4,
  parameter int IW = 2,
  parameter int OW = 2,
  parameter int RST_STATE = 0,
  parameter int CW = 16,
  localparam int SW = (NS > 2) ? $clog2(NS) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             run,
  input  logic [IW-1:0]    in,
  input  logic             cfg_we,
  input  logic [SW+IW-1:0] cfg_addr,
  input  logic [SW-1:0]    cfg_next,
  input  logic [OW-1:0]    cfg_out,
  output logic [OW-1:0]    out,
  output logic [SW-1:0]    state,
  output logic [CW-1:0]    step_cnt,
  output logic             cfg_err
);
  localparam int NE = 2 ** (SW + IW);
  localparam logic [SW-1:0] RS = SW'(RST_STATE);
  localparam logic [SW:0] NSV = (SW + 1)'(NS);
  logic [SW-1:0] nxt_tbl [NE];
  logic [OW-1:0] out_tbl [NE];
  logic [SW+IW-1:0] idx;
  logic cfg_ok;
  assign idx = {state, in};
  assign cfg_ok = ({1'b0, cfg_next} < NSV) && ({1'b0, cfg_addr[SW+IW-1:IW]} < NSV);
  // table, state and counter: clear beats write, write stalls stepping
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= RS;
      step_cnt <= '0;
      cfg_err <= 1'b0;
      for (int k = 0; k < NE; k++) begin
        nxt_tbl[k] <= RS;
        out_tbl[k] <= '0;
      end
    end else if (clr) begin
      state <= RS;
      step_cnt <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_ok) begin
        nxt_tbl[cfg_addr] <= cfg_next;
        out_tbl[cfg_addr] <= cfg_out;
      end else cfg_err <= 1'b1;
    end else if (run) begin
      state <= nxt_tbl[idx];
      step_cnt <= step_cnt + CW'(1);
    end
`ifdef FSM_OUT_REG_EN
  // registered output captured on each step edge, held otherwise
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) out <= '0;
    else if (clr) out <= '0;
    else if (!cfg_we && run) out <= out_tbl[idx];
`else
  // combinational Mealy output, forced to zero while idle
  always_comb out = run ? out_tbl[idx] : '0;
`endif
endmodule

// File: tb/tb_fsm_table_engine.sv
// tb_fsm_table_engine: directed checks of fsm_table_engine, default, NS=3 and CW=3 instances
module tb_fsm_table_engine;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  logic clr = 0, run = 0, cfg_we = 0;
  logic [1:0] in = 0, cfg_next = 0, cfg_out = 0, out, state;
  logic [3:0] cfg_addr = 0;
  logic [15:0] step_cnt;
  logic cfg_err;
  logic clr3 = 0, run3 = 0, cfg_we3 = 0;
  logic [1:0] in3 = 0, cfg_next3 = 0, cfg_out3 = 0, out3, state3;
  logic [3:0] cfg_addr3 = 0;
  logic [15:0] step_cnt3;
  logic cfg_err3;
  logic runw = 0;
  logic [1:0] outw, statew;
  logic [2:0] step_cntw;
  logic cfg_errw;
  int n_chk = 0, n_fail = 0;
  logic [3:0] tbl [16];
  logic [1:0] seq_in [8], seq_out [8], seq_st [8];

  fsm_table_engine dut (.clk(clk), .rstn(rstn), .clr(clr), .run(run), .in(in), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_next(cfg_next), .cfg_out(cfg_out), .out(out), .state(state),
    .step_cnt(step_cnt), .cfg_err(cfg_err));
  fsm_table_engine #(.NS(3)) dut3 (.clk(clk), .rstn(rstn), .clr(clr3), .run(run3), .in(in3),
    .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_next(cfg_next3), .cfg_out(cfg_out3), .out(out3),
    .state(state3), .step_cnt(step_cnt3), .cfg_err(cfg_err3));
  fsm_table_engine #(.CW(3)) dutw (.clk(clk), .rstn(rstn), .clr(1'b0), .run(runw), .in(2'b00),
    .cfg_we(1'b0), .cfg_addr(4'h0), .cfg_next(2'b00), .cfg_out(2'b00), .out(outw), .state(statew),
    .step_cnt(step_cntw), .cfg_err(cfg_errw));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic prog(input logic [3:0] a, input logic [1:0] nx, input logic [1:0] o);
    cfg_addr = a; cfg_next = nx; cfg_out = o; cfg_we = 1;
    tick();
    cfg_we = 0;
  endtask

  task automatic prog3(input logic [3:0] a, input logic [1:0] nx, input logic [1:0] o);
    cfg_addr3 = a; cfg_next3 = nx; cfg_out3 = o; cfg_we3 = 1;
    tick();
    cfg_we3 = 0;
  endtask

  task automatic step(input string tag, input logic [1:0] iv, input logic [1:0] eo, input logic [1:0] es);
    in = iv; run = 1; #1;
`ifndef FSM_OUT_REG_EN
    chk({tag, " out"}, out, eo);
`endif
    tick();
`ifdef FSM_OUT_REG_EN
    chk({tag, " out"}, out, eo);
`endif
    chk({tag, " state"}, state, es);
  endtask

  task automatic step3(input string tag, input logic [1:0] iv, input logic [1:0] eo, input logic [1:0] es);
    in3 = iv; run3 = 1; #1;
`ifndef FSM_OUT_REG_EN
    chk({tag, " out"}, out3, eo);
`endif
    tick();
`ifdef FSM_OUT_REG_EN
    chk({tag, " out"}, out3, eo);
`endif
    chk({tag, " state"}, state3, es);
  endtask

  initial begin
    tbl = '{4'h2, 4'h2, 4'h7, 4'h7, 4'hE, 4'h9, 4'hE, 4'h9,
            4'hF, 4'hA, 4'h4, 4'h4, 4'h0, 4'hA, 4'hC, 4'hC};
    seq_in  = '{2'd3, 2'd2, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
    seq_out = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2};
    seq_st  = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    repeat (2) tick();
    rstn = 1;
    chk("rst state", state, 0);
    chk("rst out", out, 0);
    chk("rst cnt", step_cnt, 0);
    chk("rst err", cfg_err, 0);
    chk("rst err3", cfg_err3, 0);
    for (int k = 0; k < 3; k++) step($sformatf("blank%0d", k), 2'd3, 2'd0, 2'd0);
    chk("blank cnt", step_cnt, 3);
    rstn = 0; #1;
    chk("async rst cnt", step_cnt, 0);
    chk("async rst state", state, 0);
    chk("async rst out", out, 0);
    tick();
    rstn = 1;
    for (int k = 0; k < 2; k++) step($sformatf("post%0d", k), 2'd3, 2'd0, 2'd0);
    chk("post rst cnt", step_cnt, 2);
    run = 0;
    for (int k = 0; k < 16; k++) prog(4'(k), tbl[k][3:2], tbl[k][1:0]);
    chk("prog cnt hold", step_cnt, 2);
    chk("prog err", cfg_err, 0);
    in = 2; clr = 1;
    tick();
    clr = 0;
    chk("clr cnt", step_cnt, 0);
    chk("clr state", state, 0);
    chk("idle out", out, 0);
    for (int k = 0; k < 8; k++) step($sformatf("seq%0d", k), seq_in[k], seq_out[k], seq_st[k]);
    chk("seq cnt", step_cnt, 8);
    step("toB", 2'd2, 2'd3, 2'd1);
    step("toC", 2'd1, 2'd1, 2'd2);
    in = 1; cfg_we = 1; cfg_addr = 4'd9; cfg_next = 2'd3; cfg_out = 2'd3; #1;
`ifndef FSM_OUT_REG_EN
    chk("stall old out", out, 2);
`endif
    tick();
    cfg_we = 0; #1;
    chk("stall state", state, 2);
    chk("stall cnt", step_cnt, 10);
`ifdef FSM_OUT_REG_EN
    chk("stall out hold", out, 1);
`else
    chk("stall new out", out, 3);
`endif
    step("newC01", 2'd1, 2'd3, 2'd3);
    chk("newC01 cnt", step_cnt, 11);
    in = 0; clr = 1; cfg_we = 1; cfg_addr = 4'd0; cfg_next = 2'd1; cfg_out = 2'd1;
    tick();
    clr = 0; cfg_we = 0; #1;
    chk("clrD state", state, 0);
    chk("clrD cnt", step_cnt, 0);
    chk("clrD err", cfg_err, 0);
`ifdef FSM_OUT_REG_EN
    chk("clrD out", out, 0);
`else
    chk("clrD out", out, 2);
`endif
    step("intactA00", 2'd0, 2'd2, 2'd0);
    step("intactA10", 2'd2, 2'd3, 2'd1);
    chk("intact cnt", step_cnt, 2);
    run = 0;
    prog3(4'd0, 2'd1, 2'd3);
    chk("ns3 legal err", cfg_err3, 0);
    prog3(4'd0, 2'd3, 2'd0);
    chk("ns3 bad next err", cfg_err3, 1);
    prog3(4'd12, 2'd0, 2'd2);
    chk("ns3 bad addr err", cfg_err3, 1);
    step3("ns3 s0", 2'd0, 2'd3, 2'd1);
    chk("ns3 err hold", cfg_err3, 1);
    step3("ns3 s1", 2'd0, 2'd0, 2'd0);
    step3("ns3 s2", 2'd0, 2'd3, 2'd1);
    chk("ns3 err hold2", cfg_err3, 1);
    chk("ns3 cnt", step_cnt3, 3);
    run3 = 0; clr3 = 1;
    tick();
    clr3 = 0;
    chk("ns3 clr err", cfg_err3, 0);
    chk("ns3 clr state", state3, 0);
    runw = 1;
    repeat (7) tick();
    chk("wrap cnt7", step_cntw, 7);
    tick();
    runw = 0;
    chk("wrap cnt0", step_cntw, 0);
    chk("wrap state", statew, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fsm_table_engine.md
Name: fsm_table_engine

Overview:
- Parametrised, table-driven Mealy state machine engine.
- Next-state and output function is held in a run-time programmable table indexed by {state, in}. One block serves any small control FSM with up to NS states, IW input bits and OW output bits.
- Sits beside control datapaths. Configured through a simple write port, then stepped once per clock while run is high.

Parameters:
- NS, 4, number of legal states (2..256); state width SW = max(1, $clog2(NS))
- IW, 2, input vector width (1..4)
- OW, 2, output vector width (1..16)
- RST_STATE, 0, state entered on reset/clear; must be < NS
- CW, 16, width of step counter

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous soft clear
- run  in  1  step enable
- in  in  IW  FSM input vector
- cfg_we  in  1  table write strobe
- cfg_addr  in  SW+IW  table index {state, in}
- cfg_next  in  SW  next-state field to write
- cfg_out  in  OW  output field to write
- out  out  OW  FSM output
- state  out  SW  current state
- step_cnt  out  CW  number of transitions taken, wraps
- cfg_err  out  1  sticky: illegal table write rejected

Behaviour:
- Table: NS*2^IW entries of {next[SW], out[OW]}, entry index = {state, in}. Indices with state field >= NS are unused; writes to them are rejected.
- Reset (rstn=0, async):
  - state=RST_STATE, step_cnt=0, cfg_err=0.
  - Every table entry = {RST_STATE, 0}, giving out=0.
- Priority per rising edge: clr > cfg_we > run step.
- clr:
  - state<=RST_STATE, step_cnt<=0, cfg_err<=0.
  - Table untouched; a cfg_we in the same cycle is ignored.
- cfg_we (no clr):
  - Writes the entry if cfg_next < NS and the cfg_addr state field < NS. Otherwise the write is dropped and cfg_err<=1 (sticky).
  - State and step_cnt hold during a write cycle even if run=1.
- Step (run=1, no clr, no cfg_we):
  - state<=table[{state,in}].next.
  - step_cnt<=step_cnt+1, modulo 2^CW.
  - A self-loop counts as a step.
- run=0: state and step_cnt hold.
- out (combinational Mealy, default build):
  - out = table[{state,in}].out when run=1, else 0.
  - Valid in the same cycle as in; zero latency from in to out.
- Read/write collision: a write to the entry currently addressed shows on out only from the cycle after the write edge.
- Only the table write path can produce state >= NS, and that path is blocked. No state beyond NS-1 is ever reachable after reset.

Optional Feature:
- Macro FSM_OUT_REG_EN.
- Defined:
  - out is a register loaded with table[{state,in}].out on every step edge.
  - out holds when run=0 or during a write cycle, and clears to 0 on rstn/clr.
  - Latency is one cycle: the out value for a step appears after that step's edge.
- Undefined: combinational Mealy out as above.

Test Plan:
- Reset check:
  - Stimulus: assert rstn=0 mid-run, then release.
  - Required: state=0, out=0, step_cnt=0, cfg_err=0. After release with run=1 and an unprogrammed table, state stays 0 and out=0 while step_cnt increments.
- Programmed 4-state machine, default params, encoding A=0 B=1 C=2 D=3, in={i,j}.
  - Table, shown as in -> next/out:
    - A: 0x->A/10, 1x->B/11
    - B: x0->D/10, x1->C/01
    - C: 00->D/11, 01->C/10, 1x->B/00
    - D: 00->A/00, 01->C/10, 1x->D/00
  - Stimulus: in sequence 11,10,01,01,00,10,00,00.
  - Required out: 11,10,10,10,11,00,00,10.
  - Required state after each edge: B,D,C,C,D,D,A,A.
  - Required step_cnt: 8.
- Write-stall: cfg_we=1 with run=1 in state C -> state stays C, step_cnt unchanged, and the new entry is visible on out next cycle.
- Illegal write, NS=3 instance:
  - Stimulus: cfg_next=3.
  - Required: entry unchanged and cfg_err=1, holding through further steps.
  - Then clr=1 -> cfg_err=0 and state=RST_STATE.
- Clear and wrap:
  - clr in state D (with cfg_we=1 at the same time) -> state=0, step_cnt=0, the write is ignored, and the table is otherwise intact.
  - CW=3 instance: 8 steps -> step_cnt back to 0.
- FSM_OUT_REG_EN build: repeat the programmed-machine scenario -> out sequence lags by one cycle (0,11,10,10,10,11,00,00,10).
